// File: rtl/cntdrv_pkg.sv
// Shared types and constants for the counter command driver.
package cntdrv_pkg;

  localparam int unsigned CNT_W = 3;

  localparam logic OP_INC  = 1'b0;
  localparam logic OP_LOAD = 1'b1;

  typedef struct packed {
    logic             op;
    logic [CNT_W-1:0] data;
  } cmd_t;

  typedef enum logic {StIdle, StIssue} state_e;

endpackage

// File: rtl/cntdrv_fifo.sv
// Registered command FIFO: pops see only entries written at earlier edges, pushes refused when full.
module cntdrv_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full blocks the push even when a pop happens at the same edge.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (do_push && !do_pop) begin
      count_d = count_q + (PtrW + 1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/counter_cmd_driver.sv
// Queues LOAD / INC-burst commands and drives the counter's ld/inc/data_in one beat per clock.
// Define CNTDRV_SHADOW_EN to add a shadow copy of the counter and a sticky mismatch flag.
module counter_cmd_driver #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [CNT_W-1:0] cmd_data,
  output logic             ld,
  output logic             inc,
  output logic [CNT_W-1:0] data_in,
`ifdef CNTDRV_SHADOW_EN
  input  logic [CNT_W-1:0] cnt_value,
  output logic             mismatch,
`endif
  output logic             busy
);

  import cntdrv_pkg::*;

  logic [CNT_W:0]         fifo_rdata;
  logic                   fifo_full, fifo_empty, fifo_pop;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   head_op;
  logic [CNT_W-1:0]       head_data;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic             ld_q, ld_d;
  logic             inc_q, inc_d;
  logic [CNT_W-1:0] data_q, data_d;

  cntdrv_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CNT_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid),
    .pop_i   (fifo_pop),
    .wdata_i ({cmd_op, cmd_data}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_op   = fifo_rdata[CNT_W];
  assign head_data = fifo_rdata[CNT_W-1:0];
  assign cmd_ready = !fifo_full;

  // A new command is taken on the same edge the previous burst's last beat ends: no bubbles.
  always_comb begin
    state_d  = state_q;
    beats_d  = beats_q;
    ld_d     = 1'b0;
    inc_d    = 1'b0;
    data_d   = '0;
    fifo_pop = 1'b0;
    if ((state_q == StIdle || beats_q == '0) && !fifo_empty) begin
      fifo_pop = 1'b1;
      state_d  = StIssue;
      if (head_op == OP_LOAD) begin
        ld_d    = 1'b1;
        data_d  = head_data;
        beats_d = '0;
      end else begin
        inc_d   = 1'b1;
        beats_d = head_data;
      end
    end else if (beats_q != '0) begin
      inc_d   = 1'b1;
      beats_d = beats_q - CNT_W'(1);
    end else begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      beats_q <= '0;
      ld_q    <= 1'b0;
      inc_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      ld_q    <= ld_d;
      inc_q   <= inc_d;
      data_q  <= data_d;
    end
  end

  assign ld      = ld_q;
  assign inc     = inc_q;
  assign data_in = data_q;
  assign busy    = (state_q == StIssue) || (fifo_count != '0);

`ifdef CNTDRV_SHADOW_EN
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             mismatch_q, mismatch_d;

  // Shadow tracks what the counter should hold given the strobes already issued.
  always_comb begin
    shadow_d = shadow_q;
    if (ld_q) begin
      shadow_d = data_q;
    end else if (inc_q) begin
      shadow_d = shadow_q + CNT_W'(1);
    end
    mismatch_d = mismatch_q || (cnt_value != shadow_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q   <= '0;
      mismatch_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`endif

endmodule

// File: doc/counter_cmd_driver.md
Name: counter_cmd_driver

Overview:
- Upstream command stage for the 3-bit loadable counter.
- Accepts load and increment-burst commands over a valid/ready handshake and queues them in a small FIFO.
- Drives the counter's ld, inc and data_in one beat per clock, with no bubbles between queued commands.
- Decouples software-style command producers, such as testbench BFMs or a bus bridge, from the counter's single-cycle control interface.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 3, counter/data width; must match the counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- cmd_valid  input  1  producer presents a command.
- cmd_ready  output  1  driver can accept; equals !fifo_full.
- cmd_op  input  1  0 = INC burst, 1 = LOAD.
- cmd_data  input  CNT_W  LOAD: value to load; INC: burst length minus 1 (0 means 1 increment, 7 means 8).
- ld  output  1  registered; load strobe to the counter.
- inc  output  1  registered; increment strobe to the counter.
- data_in  output  CNT_W  registered; load value, valid when ld=1, otherwise 0.
- busy  output  1  high while a beat is being issued or the FIFO is non-empty.

Behaviour:
- Reset (rst=1 at a posedge):
  - FIFO flushed; any in-progress burst is aborted.
  - Outputs ld=0, inc=0, data_in=0, busy=0, cmd_ready=1.
  - Reset mid-burst drops the remaining beats; nothing is replayed after reset.
- Handshake:
  - A command is accepted at a posedge where cmd_valid && cmd_ready.
  - cmd_ready depends only on FIFO occupancy, never on cmd_valid.
  - When full, no push occurs even if a pop happens in the same cycle; cmd_ready rises the cycle after the pop.
  - cmd_op and cmd_data are ignored when cmd_valid=0.
- Issue engine: two states, IDLE and ISSUE, plus a beats_left counter of width CNT_W.
  - At each posedge, if (state==IDLE or beats_left==0) and the FIFO is non-empty: pop the head and present its first beat.
    - LOAD: ld=1, data_in=cmd_data, beats_left=0.
    - INC: inc=1, beats_left=cmd_data.
  - Else if beats_left>0: inc=1, beats_left decrements.
  - Else: ld=0, inc=0, data_in=0, state returns to IDLE.
- Latency and ordering:
  - A command accepted at edge k into an empty, idle driver produces its first strobe after edge k+1.
  - Consecutive queued commands issue back-to-back with zero idle cycles.
  - ld and inc are never high in the same cycle.
  - Commands issue strictly in FIFO order.
- Push into an empty FIFO and pop at the same edge is not allowed; pop sees only entries written at earlier edges (registered FIFO, no bypass).
- Occupancy counter width is clog2(DEPTH)+1; full is count==DEPTH, empty is count==0.
- busy = (state==ISSUE) || !empty.

Optional Feature:
- Macro: CNTDRV_SHADOW_EN.
- Defined:
  - Adds input cnt_value [CNT_W-1:0], fed from the counter's data_out.
  - Adds output mismatch (1 bit).
  - The driver keeps a shadow register with reset value 0. At each posedge it loads data_in when ld=1, adds 1 modulo 2^CNT_W when inc=1, and otherwise holds.
  - Each cycle it compares cnt_value with the shadow; any difference sets mismatch.
  - mismatch is sticky until rst.
- Not defined: neither port exists and there is no shadow logic.

Decomposition:
- Package cntdrv_pkg: OP_INC=1'b0, OP_LOAD=1'b1, CNT_W=3, and a command struct type {op, data}.
- One natural sub-module, cntdrv_fifo: synchronous, DEPTH-parameterised, with push/pop/full/empty/count. It is reset by rst.

Test Plan:
- LOAD 5 into an idle driver: one cycle after acceptance ld=1 and data_in=5 for exactly 1 cycle; counter then reads 5.
- INC with cmd_data=2 after LOAD 6: inc high for 3 consecutive cycles; counter goes 6→7→0→1 (wrap).
- Push 5 commands with DEPTH=4 while the driver is stalled behind an INC-7 burst: cmd_ready drops after the 4th accept; the 5th is held until a pop; all issue in order with no gaps.
- Assert rst on the 2nd beat of an INC-7 burst: next cycle inc=0 and busy=0, FIFO empty; counter and shadow both 0.
- Alternate LOAD 3 and INC 0 back-to-back ×4: ld and inc alternate every cycle and are never both high.
- CNTDRV_SHADOW_EN defined: force the counter's data_out to 0 after LOAD 4; mismatch rises next cycle and stays high until rst.
